// File: rtl/harness_pkg.sv
// Shared constants and types for the multi-project harness scheduler.
package harness_pkg;

  // Wishbone slave region owned by the harness
  localparam logic [31:0] WB_BASE    = 32'h3000_0000;
  localparam logic [11:0] CTRL_OFF   = 12'hF00;
  localparam logic [11:0] STATUS_OFF = 12'hF04;
  localparam logic [31:0] WIN_STRIDE = 32'h0000_0100;
  localparam int          WIN_SHIFT  = $clog2(WIN_STRIDE);

  // Scheduler phases: running, all-clocks-off gap, timed reset of the incoming project
  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_GAP = 2'd1,
    ST_RST = 2'd2
  } sched_state_e;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address classifier for the harness Wishbone region.
module wb_addr_decode
  import harness_pkg::*;
#(
  parameter int NUM_PROJECTS = 8
) (
  input  logic [31:0] adr,
  output logic        in_range,
  output logic        is_ctrl,
  output logic        is_status,
  output logic        is_window,
  output logic [3:0]  win_idx
);

  // Only the 4 KiB page at WB_BASE belongs to us; anything else is a null target
  assign in_range  = (adr[31:12] == WB_BASE[31:12]);
  assign win_idx   = adr[WIN_SHIFT +: 4];
  assign is_ctrl   = in_range && (adr[11:0] == CTRL_OFF);
  assign is_status = in_range && (adr[11:0] == STATUS_OFF);
  // Window slots past the last project (including the register page) are not windows
  assign is_window = in_range && (win_idx < 4'(NUM_PROJECTS));

endmodule

// File: rtl/project_sched.sv
// Active-project scheduler: Wishbone decode, per-project strobes/readback,
// and the gap + timed-reset sequence on every project switch.
module project_sched
  import harness_pkg::*;
#(
  parameter int NUM_PROJECTS = 8,
  parameter int RESET_CYCLES = 16,
  parameter int GAP_CYCLES   = 2,
  parameter int SEL_W        = $clog2(NUM_PROJECTS)
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [31:0]                  wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  output logic [SEL_W-1:0]             proj_sel_o,
  output logic [NUM_PROJECTS-1:0]      proj_clk_en_o,
  output logic [NUM_PROJECTS-1:0]      proj_reset_o,
  output logic [NUM_PROJECTS-1:0]      proj_wb_update_o,
  input  logic [32*NUM_PROJECTS-1:0]   proj_rdata_i
);

  localparam int CNT_MAX = (RESET_CYCLES > GAP_CYCLES) ? RESET_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [NUM_PROJECTS-1:0] ONE = NUM_PROJECTS'(1);

  logic              in_range, is_ctrl, is_status, is_window;
  logic [3:0]        win_idx;

  sched_state_e      state;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  active;
  logic              dropped;
  logic              ack_q;
  logic [31:0]       dat_q;
  logic [NUM_PROJECTS-1:0] upd_q, clk_en_q, reset_q;

  // CTRL writes are captured at request time and acted on in the ack cycle,
  // so the switch becomes visible on the cycle after ack
  logic              ctrl_wr_q;
  logic [SEL_W-1:0]  ctrl_sel_q;
  logic              ctrl_soft_q;

  logic              req, busy, sel_oob;
  logic              win_wr_ok, win_wr_drop, status_rd;
  logic              ctrl_bad, ctrl_new, ctrl_soft;
  logic              drop_set;
  logic [NUM_PROJECTS-1:0] oh_active;
  logic [31:0]       win_rdata, rd_val;
  logic              unused_bits;

  wb_addr_decode #(.NUM_PROJECTS(NUM_PROJECTS)) u_dec (
    .adr       (wbs_adr_i),
    .in_range  (in_range),
    .is_ctrl   (is_ctrl),
    .is_status (is_status),
    .is_window (is_window),
    .win_idx   (win_idx)
  );

  assign unused_bits = ^{in_range, wbs_dat_i[31:9], wbs_dat_i[7:SEL_W]};

  assign req       = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign busy      = (state != ST_RUN);
  assign oh_active = ONE << active;
  assign sel_oob   = ({1'b0, ctrl_sel_q} >= (SEL_W+1)'(NUM_PROJECTS));

  // Window writes only land on the running active project with a full-word select
  assign win_wr_ok   = req & wbs_we_i & is_window & (wbs_sel_i == 4'hF)
                     & (win_idx == 4'(active)) & ~busy;
  assign win_wr_drop = req & wbs_we_i & is_window & ~win_wr_ok;
  assign status_rd   = req & ~wbs_we_i & is_status;

  assign ctrl_bad  = ctrl_wr_q & (sel_oob | busy);
  assign ctrl_new  = ctrl_wr_q & ~ctrl_bad & (ctrl_sel_q != active);
  assign ctrl_soft = ctrl_wr_q & ~ctrl_bad & (ctrl_sel_q == active) & ctrl_soft_q;
  assign drop_set  = win_wr_drop | ctrl_bad;

  // Readback slice of the addressed window, valid for any project
  always_comb begin
    win_rdata = '0;
    for (int p = 0; p < NUM_PROJECTS; p++)
      if (win_idx == 4'(p)) win_rdata = proj_rdata_i[32*p +: 32];
  end

  // Read value for the current request; a drop landing this cycle reads as set
  always_comb begin
    rd_val = '0;
    if (is_window) begin
      rd_val = win_rdata;
    end else if (is_ctrl) begin
      rd_val[SEL_W-1:0] = active;
    end else if (is_status) begin
      rd_val[0]           = busy;
      rd_val[1]           = dropped | drop_set;
      rd_val[SEL_W+7:8]   = active;
    end
  end

  // Bus side: single-cycle ack, registered read data, update strobes, sticky dropped
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      upd_q       <= '0;
      ctrl_wr_q   <= 1'b0;
      ctrl_sel_q  <= '0;
      ctrl_soft_q <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      ack_q       <= req;
      dat_q       <= (req & ~wbs_we_i) ? rd_val : '0;
      upd_q       <= win_wr_ok ? oh_active : '0;
      ctrl_wr_q   <= req & wbs_we_i & is_ctrl;
      ctrl_sel_q  <= wbs_dat_i[SEL_W-1:0];
      ctrl_soft_q <= wbs_dat_i[8];
      if (drop_set)       dropped <= 1'b1;
      else if (status_rd) dropped <= 1'b0;
    end
  end

  // Switch sequencer; clock-enable/reset outputs are registered alongside the state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_RST;
      cnt      <= CNT_W'(RESET_CYCLES);
      active   <= '0;
      clk_en_q <= '0;
      reset_q  <= '1;
    end else begin
      case (state)
        ST_RUN: begin
          if (ctrl_new) begin
            active   <= ctrl_sel_q;
            state    <= ST_GAP;
            cnt      <= CNT_W'(GAP_CYCLES - 1);
            clk_en_q <= '0;
            reset_q  <= '1;
          end else if (ctrl_soft) begin
            state    <= ST_RST;
            cnt      <= CNT_W'(RESET_CYCLES - 1);
            clk_en_q <= oh_active;
            reset_q  <= '1;
          end else begin
            clk_en_q <= oh_active;
            reset_q  <= ~oh_active;
          end
        end
        ST_GAP: begin
          clk_en_q <= '0;
          reset_q  <= '1;
          if (cnt == '0) begin
            state    <= ST_RST;
            cnt      <= CNT_W'(RESET_CYCLES - 1);
            clk_en_q <= oh_active;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RST: begin
          clk_en_q <= oh_active;
          reset_q  <= '1;
          if (cnt == '0) begin
            state   <= ST_RUN;
            reset_q <= ~oh_active;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_RST;
          cnt      <= CNT_W'(RESET_CYCLES - 1);
          clk_en_q <= '0;
          reset_q  <= '1;
        end
      endcase
    end
  end

  assign wbs_ack_o        = ack_q;
  assign wbs_dat_o        = dat_q;
  assign proj_sel_o       = active;
  assign proj_clk_en_o    = clk_en_q;
  assign proj_reset_o     = reset_q;
  assign proj_wb_update_o = upd_q;

endmodule

// File: doc/project_sched.md
# project_sched

Project scheduler and Wishbone decoder for the multi-project harness. Owns the active-project selection and decodes the management SoC's Wishbone slave bus into per-project update strobes and read-data returns. Sequences every project switch with a clock gap and a timed reset, so exactly one project runs at a time. Sits between the Wishbone slave ports and the per-project clk/reset/wb_update/readback nets.

## Interface
- NUM_PROJECTS, 8: number of projects; allowed range 2..15.
- RESET_CYCLES, 16: reset hold length for the incoming project; must be ≥1.
- GAP_CYCLES, 2: all-clocks-off interval on a switch; must be ≥1.
- SEL_W, $clog2(NUM_PROJECTS): width of the select field.

Ports:
- wb_clk_i  in  1  the only clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  registered read data.
- proj_sel_o  out  SEL_W  active project index, used to steer the io mux.
- proj_clk_en_o  out  NUM_PROJECTS  per-project clock enable, at most one bit high.
- proj_reset_o  out  NUM_PROJECTS  per-project reset, active-high.
- proj_wb_update_o  out  NUM_PROJECTS  one-cycle write strobes.
- proj_rdata_i  in  32*NUM_PROJECTS  per-project readback; slice p is [32p+31:32p].

## Operation
Address map, relative to 0x3000_0000:
- Project window p: 0x100·p .. 0x100·p+0xFF.
- CTRL at 0xF00 (R/W): [SEL_W-1:0] select; [8] soft reset (write-only, reads 0).
- STATUS at 0xF04 (RO): [0] busy; [1] dropped, sticky and cleared by a read; [SEL_W+7:8] active select.
- Any other address, including a high address nibble other than 0x3: acked; reads return 0 and writes are discarded.

Window writes:
- A write pulses proj_wb_update_o[p] for one cycle only when all of these hold: wbs_sel_i==4'hF, p==active, and state==RUN.
- Otherwise the write is acked and dropped, and STATUS.dropped is set.

Window reads: return proj_rdata_i slice p. This works for any p, whether or not p is active.

FSM states are RUN, GAP and RST.
- CTRL write with select ≥ NUM_PROJECTS, or any CTRL write while busy: ignored and dropped is set.
- CTRL write with a new select: active is updated, then the FSM goes to GAP.
- CTRL write with the same select and [8]=1: FSM goes to RST.
- CTRL write with the same select and [8]=0: no action.
- GAP lasts GAP_CYCLES. All proj_clk_en_o bits are 0 and all proj_reset_o bits are 1. The FSM then goes to RST.
- RST lasts RESET_CYCLES. proj_clk_en_o = onehot(active) and proj_reset_o = all 1. The FSM then goes to RUN.
- RUN: proj_clk_en_o = onehot(active) and proj_reset_o = ~onehot(active).
- busy = (state != RUN).
- Inactive projects are always held in reset with their clock disabled.

## Timing
- While wb_rst_i is high:
  - outputs: ack=0, dat_o=0, proj_sel_o=0, proj_clk_en_o=0, proj_reset_o=all 1, proj_wb_update_o=0;
  - internal: dropped=0, state=RST, counter loaded with RESET_CYCLES.
- After reset deasserts, project 0 therefore gets a full reset before RUN.
- wb_rst_i asserted at any point, including mid-GAP or mid-RST, aborts the sequence immediately. Active returns to 0.
- Ack latency is 1: a cycle with stb&cyc&!ack produces ack=1 on the next cycle for exactly one cycle. Back-to-back requests are therefore acked every other cycle.
- wbs_dat_o is valid in the ack cycle and is 0 outside ack cycles.
- proj_wb_update_o[p] is asserted in the same cycle as ack. The project samples wbs_dat_i/wbs_adr_i there; the master holds them until ack.
- A CTRL write takes effect on the cycle after ack: proj_sel_o changes and clk_en drops to 0 together.
- A new select reaches RUN GAP_CYCLES+RESET_CYCLES cycles after the ack cycle.
- Dropped set and STATUS read in the same cycle: the read returns 1 and the bit stays 1.

## Structure
- Shared package `harness_pkg` holds:
  - constants: the base address, the CTRL and STATUS offsets, the window stride (0x100);
  - the FSM state enum (RUN/GAP/RST).
- One sub-module, `wb_addr_decode`, is combinational. From wbs_adr_i it produces: is_ctrl, is_status, is_window, the window index, and in_range.
- FSM, counter, ack and read-data registers stay in project_sched.

## Test plan
- Reset release:
  - check proj_reset_o=8'hFF and clk_en=8'h00 during reset;
  - check clk_en=8'h01 for RESET_CYCLES=16 cycles with reset=8'hFF;
  - then check reset=8'hFE and STATUS.busy=0.
- Write 0x3000_0F00 ← 3:
  - check clk_en=0 for 2 cycles, then 8'h08 with reset=8'hFF for 16 cycles;
  - then check reset=8'hF7 and proj_sel_o=3.
- Active=4, write 0x3000_0404 sel=F:
  - check proj_wb_update_o=8'h10 for one cycle, coincident with ack.
- Active=4:
  - write window 1: check no strobe and dropped=1;
  - byte write (sel=4'h1) to window 4: check no strobe;
  - read STATUS: check it returns dropped=1, then a second read returns 0.
- With proj_rdata_i slice 4 = 0xDEAD_BEEF:
  - read 0x3000_0418: check dat_o=0xDEADBEEF in the ack cycle;
  - read 0x3000_0F10: check 0 is returned with an ack.
- CTRL ←5 during RST: check it is ignored.
- Assert wb_rst_i mid-GAP: check sel=0 and a fresh 16-cycle reset of project 0 follows.
